// File: rtl/axis_unpack.sv
// axis_unpack: AXI-Stream width down-converter. It splits each DW_IN input word
//   into R = DW_IN/DW_OUT output lanes, sending the least-significant lane first.
// Latency: the first lane is valid one cycle after the input handshake.
//   A new word loads on the same edge that takes the final lane, so words follow
//   each other with no bubble.
// Backpressure: while m_tready is low, the buffered lane holds stable and
//   s_tready stays low.
//
// Ports:
//   clk, reset            single rising-edge clock; asynchronous active-high reset
//   s_tdata/tvalid/tready/tlast  wide input stream
//   m_tdata/tvalid/tready/tlast  narrow output stream
//   s_tkeep (optional)    one bit per output lane; present only with AXIS_UNPACK_KEEP_EN
//
// Optional feature macro: AXIS_UNPACK_KEEP_EN
//   When it is defined, lanes whose keep bit is 0 are skipped.
//   A word with all keep bits at 0 is accepted and dropped, and its s_tlast is lost.
module axis_unpack #(
  parameter int DW_IN  = 32,
  parameter int DW_OUT = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DW_IN-1:0]          s_tdata,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic                      s_tlast,
`ifdef AXIS_UNPACK_KEEP_EN
  input  logic [DW_IN/DW_OUT-1:0]   s_tkeep,
`endif
  output logic [DW_OUT-1:0]         m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast
);

  localparam int R  = DW_IN / DW_OUT;
  localparam int CW = (R > 1) ? $clog2(R) : 1;

  generate
    if ((DW_IN % DW_OUT) != 0 || R < 2) begin : g_bad_ratio
      $error("axis_unpack: DW_IN must be an integer multiple (>=2) of DW_OUT");
    end
  endgenerate

  logic [DW_IN-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [CW-1:0]    first_lane, final_lane, next_lane;
  logic             load_busy;
  logic             at_final, in_hs, out_hs;

`ifdef AXIS_UNPACK_KEEP_EN
  logic [R-1:0]     keep_q, keep_d;

  // The lowest set bit of the incoming keep is the first lane.
  // The highest set bit of the stored keep is the final lane.
  // The next lane is the lowest set bit above cnt.
  always_comb begin
    first_lane = '0;
    for (int i = R - 1; i >= 0; i--) begin
      if (s_tkeep[i]) first_lane = CW'(i);
    end
    final_lane = '0;
    for (int i = 0; i < R; i++) begin
      if (keep_q[i]) final_lane = CW'(i);
    end
    next_lane = final_lane;
    for (int i = R - 1; i >= 0; i--) begin
      if (keep_q[i] && (i > int'(cnt_q))) next_lane = CW'(i);
    end
    // An all-zero keep word produces no output lanes.
    load_busy = |s_tkeep;
  end
`else
  always_comb begin
    first_lane = '0;
    final_lane = CW'(R - 1);
    next_lane  = cnt_q + CW'(1);
    load_busy  = 1'b1;
  end
`endif

  assign at_final = (cnt_q == final_lane);
  assign m_tvalid = busy_q;
  assign m_tdata  = data_q[cnt_q*DW_OUT +: DW_OUT];
  assign m_tlast  = busy_q & last_q & at_final;
  // The input is accepted when the buffer is empty, or when its final lane
  // leaves on this edge.
  assign s_tready = ~busy_q | (m_tready & at_final);
  assign in_hs    = s_tvalid & s_tready;
  assign out_hs   = busy_q & m_tready;

  always_comb begin
    data_d = data_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
`ifdef AXIS_UNPACK_KEEP_EN
    keep_d = keep_q;
`endif
    if (out_hs) begin
      if (at_final) busy_d = 1'b0;
      else          cnt_d  = next_lane;
    end
    // A reload takes priority over the idle transition on the final lane.
    if (in_hs) begin
      data_d = s_tdata;
      last_d = s_tlast;
      cnt_d  = first_lane;
      busy_d = load_busy;
`ifdef AXIS_UNPACK_KEEP_EN
      keep_d = s_tkeep;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      last_q <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
`ifdef AXIS_UNPACK_KEEP_EN
      keep_q <= '0;
`endif
    end else begin
      data_q <= data_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
`ifdef AXIS_UNPACK_KEEP_EN
      keep_q <= keep_d;
`endif
    end
  end

endmodule

// File: tb/tb_axis_unpack.sv
module tb_axis_unpack;
  localparam int DW_IN  = 32;
  localparam int DW_OUT = 8;
  localparam int R      = DW_IN / DW_OUT;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DW_IN-1:0]  s_tdata = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic              s_tlast = 1'b0;
  logic [DW_OUT-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready = 1'b0;
  logic              m_tlast;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  axis_unpack #(.DW_IN(DW_IN), .DW_OUT(DW_OUT)) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of the lanes still owed to the output.
  // Each accepted word appends R lanes. Only the last of them carries the
  // word's tlast. Each output handshake pops one lane.
  typedef struct packed {
    logic [DW_OUT-1:0] d;
    logic              l;
  } beat_t;
  beat_t q[$];

  always @(negedge clk) begin
    logic exp_rdy;
    if (reset) begin
      q.delete();
    end else begin
      exp_rdy = (q.size() == 0) || (q.size() == 1 && m_tready);
      chk("m_tvalid", 32'(m_tvalid), 32'(q.size() != 0));
      chk("s_tready", 32'(s_tready), 32'(exp_rdy));
      if (q.size() != 0) begin
        chk("m_tdata", 32'(m_tdata), 32'(q[0].d));
        chk("m_tlast", 32'(m_tlast), 32'(q[0].l));
      end
      // Inputs only change just after posedge, so these values hold at the next edge.
      if (q.size() != 0 && m_tready) void'(q.pop_front());
      if (s_tvalid && exp_rdy) begin
        for (int k = 0; k < R; k++) begin
          beat_t b;
          b.d = s_tdata[k*DW_OUT +: DW_OUT];
          b.l = s_tlast && (k == R - 1);
          q.push_back(b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    s_tdata  = w;
    s_tlast  = last;
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
  endtask

  // Check one presented lane at the negedge, then advance to just past the next posedge.
  task automatic expect_lane(input string name, input logic [7:0] d, input logic l);
    @(negedge clk);
    chk({name, "_vld"}, 32'(m_tvalid), 32'd1);
    chk({name, "_dat"}, 32'(m_tdata), 32'(d));
    chk({name, "_last"}, 32'(m_tlast), 32'(l));
    tick();
  endtask

  initial begin
    logic [7:0] w2 [4];
    logic [7:0] w5 [4];
    w2 = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    w5 = '{8'h44, 8'h33, 8'h22, 8'h11};

    // Reset state
    #1;
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tlast", 32'(m_tlast), 32'd0);
    chk("rst_m_tdata", 32'(m_tdata), 32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd1);
    tick(); tick();
    reset = 1'b0;
    m_tready = 1'b1;
    tick();

    // Single word, least-significant lane first, tlast only on the top lane
    send_word(32'hA1B2C3D4, 1'b1);
    for (int k = 0; k < 4; k++) expect_lane("single", w2[k], k == 3);
    @(negedge clk);
    chk("single_idle", 32'(m_tvalid), 32'd0);
    tick();

    // Back-to-back words with no bubble; s_tready is high only on lane 3
    s_tdata = 32'h03020100; s_tlast = 1'b0; s_tvalid = 1'b1;
    tick();
    s_tdata = 32'h07060504;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b2b_vld", 32'(m_tvalid), 32'd1);
      chk("b2b_dat", 32'(m_tdata), 32'(k));
      chk("b2b_s_tready", 32'(s_tready), 32'(k % 4 == 3));
      tick();
      if (k == 3) s_tvalid = 1'b0;
    end

    // Backpressure while lane 1 (C3) is presented
    send_word(32'hA1B2C3D4, 1'b1);
    expect_lane("bp", 8'hD4, 1'b0);
    m_tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_dat", 32'(m_tdata), 32'hC3);
      chk("bp_hold_vld", 32'(m_tvalid), 32'd1);
      chk("bp_s_tready", 32'(s_tready), 32'd0);
      tick();
    end
    m_tready = 1'b1;
    expect_lane("bp", 8'hC3, 1'b0);
    expect_lane("bp", 8'hB2, 1'b0);
    expect_lane("bp", 8'hA1, 1'b1);

    // Reset mid-word after D4 and C3 are sent; no clock edge is needed to clear
    send_word(32'hA1B2C3D4, 1'b1);
    expect_lane("mid", 8'hD4, 1'b0);
    expect_lane("mid", 8'hC3, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_m_tlast", 32'(m_tlast), 32'd0);
    chk("midrst_m_tdata", 32'(m_tdata), 32'd0);
    chk("midrst_s_tready", 32'(s_tready), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    send_word(32'h11223344, 1'b1);
    for (int k = 0; k < 4; k++) expect_lane("post_rst", w5[k], k == 3);

    // Random traffic, checked every cycle against the queue model
    for (int c = 0; c < 3000; c++) begin
      s_tvalid = ($urandom_range(0, 3) != 0);
      s_tdata  = $urandom;
      s_tlast  = $urandom_range(0, 1);
      m_tready = ($urandom_range(0, 3) != 0);
      tick();
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int c = 0; c < 8; c++) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
